fib_index: RTL and testbench
============================

// Module: fib_index
// PURPOSE
//  Inverse Fibonacci unit: given value x, returns the smallest index n with
//  fib(n) >= x, and flags whether x is exactly a Fibonacci number.
//  Counterpart of the forward Fibonacci generator (index -> value).
//  Iterative: one Fibonacci step per clock; start/busy/done handshake.
//  Convention: fib(0)=0, fib(1)=fib(2)=1, fib(3)=2, fib(n)=fib(n-1)+fib(n-2).
// PARAMETERS
//  w   32  datapath width of x, internal a/b registers and idx
// PORTS
//  clk     in   1  rising-edge clock; single clock domain
//  rst     in   1  synchronous, active-high reset
//  start   in   1  request; sampled only while idle (busy=0)
//  x       in   w  target value; captured on the accepting edge
//  busy    out  1  1 while iterating
//  done    out  1  single-cycle pulse: result valid
//  idx     out  w  smallest n with fib(n) >= x (last n reached if ovf)
//  is_fib  out  1  1 iff fib(idx) == x
//  ovf     out  1  1 iff fib(idx+1) exceeds 2^w-1 before reaching x
// BEHAVIOUR
//  - Reset (rst=1 at edge): state IDLE; busy=0, done=0, idx=0, is_fib=0,
//    ovf=0; a=1, b=0, i=0. Applies mid-operation: computation abandoned,
//    no done pulse; start accepted from the next edge onward.
//  - States: IDLE, RUN. IDLE->RUN on start=1. RUN->IDLE on hit or ovf.
//  - Accept edge (IDLE, start=1): xr<=x; a<=1 (fib(-1)); b<=0 (fib(0));
//    i<=0; busy<=1; idx/is_fib/ovf cleared to 0.
//  - Each RUN edge, b=fib(i):
//    hit   (b >= xr): idx<=i; is_fib<=(b==xr); ovf<=0; done<=1; ->IDLE
//    ovf   (b < xr, {1'b0,a}+{1'b0,b} carries past w bits): idx<=i;
//          is_fib<=0; ovf<=1; done<=1; ->IDLE
//    else: a<=b; b<=a+b (w bits); i<=i+1; stay RUN
//  - Hit takes priority over overflow in the same cycle.
//  - Latency: done visible k+1 cycles after the accept edge, k = final idx.
//    x=0 -> 1 cycle; x=1 -> idx=1, 2 cycles.
//  - done high exactly one cycle; busy falls on the same edge done rises.
//  - idx/is_fib/ovf hold their values until the next accept edge.
//  - start while busy: ignored; x changes while busy: no effect.
//  - start in the cycle done=1: accepted (state is already IDLE).
//  - Comparisons are unsigned; i never wraps (max index < 2^w for any w>=4).
// STRUCTURE
//  - Package fib_pkg: default width constant; state encoding
//    (IDLE=1'b0, RUN=1'b1); reset constants FIB_A0=1, FIB_B0=0.
//  - Sub-module fib_step (combinational): in a,b; out nb=a+b (w bits),
//    carry. Shared with the forward generator so both ends step identically.
//  - Top: FSM, xr/a/b/i registers, comparator, output registers.
// TESTING
//  1. rst=1 for 2 cycles, then x=55, start=1 for one cycle
//     -> done after 11 cycles; idx=10, is_fib=1, ovf=0.
//  2. x=10 -> done after 8 cycles; idx=7 (fib(7)=13), is_fib=0, ovf=0.
//  3. x=0 -> done after 1 cycle, idx=0, is_fib=1.
//     x=1 -> done after 2 cycles, idx=1, is_fib=1.
//  4. w=8, x=250 -> idx=13 (fib(13)=233), ovf=1, is_fib=0.
//     w=8, x=233 -> idx=13, is_fib=1, ovf=0 (hit beats carry).
//  5. x=55 accepted; re-pulse start with x=3 at cycle 4 -> ignored, result
//     idx=10. Assert start with x=3 in the done cycle -> accepted;
//     idx=4, is_fib=1 five cycles later.
//  6. x=55 accepted; rst at cycle 5 -> no done pulse, all outputs 0.
//     Next start with x=8 -> idx=6, is_fib=1.

Source files
------------

// File: rtl/fib_pkg.sv
// Shared constants and state encoding for the Fibonacci index/value units.
package fib_pkg;

  localparam int FIB_W  = 32;
  localparam int FIB_A0 = 1;
  localparam int FIB_B0 = 0;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/fib_step.sv
// One Fibonacci step: nb = a + b with carry out, shared by forward and inverse units.
module fib_step
  import fib_pkg::*;
#(
  parameter int w = FIB_W
) (
  input  logic [w-1:0] a,
  input  logic [w-1:0] b,
  output logic [w-1:0] nb,
  output logic         carry
);

  assign {carry, nb} = {1'b0, a} + {1'b0, b};

endmodule

// File: rtl/fib_index.sv
// Inverse Fibonacci: smallest n with fib(n) >= x, one step per clock.
module fib_index
  import fib_pkg::*;
#(
  parameter int w = FIB_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [w-1:0] x,
  output logic         busy,
  output logic         done,
  output logic [w-1:0] idx,
  output logic         is_fib,
  output logic         ovf
);

  state_t       state, state_nx;
  logic [w-1:0] xr, a, b, i, nb;
  logic         carry, accept, hit, over;

  fib_step #(.w(w)) u_step (
    .a    (a),
    .b    (b),
    .nb   (nb),
    .carry(carry)
  );

  assign busy = (state == RUN);

  // A hit is checked before the carry so an exact top-of-range value still matches.
  always_comb begin
    state_nx = state;
    accept   = 1'b0;
    hit      = 1'b0;
    over     = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          accept   = 1'b1;
          state_nx = RUN;
        end
      end
      RUN: begin
        if (b >= xr) begin
          hit      = 1'b1;
          state_nx = IDLE;
        end else if (carry) begin
          over     = 1'b1;
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      xr     <= '0;
      a      <= w'(FIB_A0);
      b      <= w'(FIB_B0);
      i      <= '0;
      done   <= 1'b0;
      idx    <= '0;
      is_fib <= 1'b0;
      ovf    <= 1'b0;
    end else begin
      state <= state_nx;
      done  <= hit | over;
      if (accept) begin
        xr     <= x;
        a      <= w'(FIB_A0);
        b      <= w'(FIB_B0);
        i      <= '0;
        idx    <= '0;
        is_fib <= 1'b0;
        ovf    <= 1'b0;
      end else if (hit) begin
        idx    <= i;
        is_fib <= (b == xr);
        ovf    <= 1'b0;
      end else if (over) begin
        idx    <= i;
        is_fib <= 1'b0;
        ovf    <= 1'b1;
      end else if (state == RUN) begin
        a <= b;
        b <= nb;
        i <= i + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_fib_index.sv
// Scoreboard bench for fib_index at w=32 and w=8.
module tb_fib_index;

  typedef struct {
    logic [31:0] idx;
    logic        isf;
    logic        ovf;
    int          acc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start32 = 1'b0;
  logic [31:0] x32 = '0;
  logic        busy32, done32, isf32, ovf32;
  logic [31:0] idx32;
  logic        start8 = 1'b0;
  logic [7:0]  x8 = '0;
  logic        busy8, done8, isf8, ovf8;
  logic [7:0]  idx8;

  exp_t sb32[$];
  exp_t sb8[$];
  exp_t m32, m8;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;

  fib_index #(.w(32)) dut32 (
    .clk(clk), .rst(rst), .start(start32), .x(x32),
    .busy(busy32), .done(done32), .idx(idx32), .is_fib(isf32), .ovf(ovf32)
  );

  fib_index #(.w(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .x(x8),
    .busy(busy8), .done(done8), .idx(idx8), .is_fib(isf8), .ovf(ovf8)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference search done in wide arithmetic so the width limit is explicit.
  function automatic void model(input logic [31:0] v, input int wd,
                                output logic [31:0] ei, output logic eis, output logic eo);
    longint unsigned fa, fb, ft, lim;
    fa = 1; fb = 0; lim = (64'd1 << wd) - 1;
    ei = '0; eis = 1'b0; eo = 1'b0;
    for (int k = 0; k < 100; k++) begin
      if (fb >= longint'(v)) begin
        ei = k; eis = (fb == longint'(v)); eo = 1'b0;
        return;
      end
      if (fa + fb > lim) begin
        ei = k; eis = 1'b0; eo = 1'b1;
        return;
      end
      ft = fa + fb; fa = fb; fb = ft;
    end
  endfunction

  always @(negedge clk) begin
    if (!rst && done32 === 1'b1) begin
      if (sb32.size() == 0) checkOutput("spurious_done32", 32'(done32), 0);
      else begin
        m32 = sb32.pop_front();
        checkOutput("idx32", idx32, m32.idx);
        checkOutput("is_fib32", 32'(isf32), 32'(m32.isf));
        checkOutput("ovf32", 32'(ovf32), 32'(m32.ovf));
        checkOutput("latency32", cyc - m32.acc, m32.idx + 1);
        checkOutput("busy_at_done32", 32'(busy32), 0);
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && done8 === 1'b1) begin
      if (sb8.size() == 0) checkOutput("spurious_done8", 32'(done8), 0);
      else begin
        m8 = sb8.pop_front();
        checkOutput("idx8", 32'(idx8), m8.idx);
        checkOutput("is_fib8", 32'(isf8), 32'(m8.isf));
        checkOutput("ovf8", 32'(ovf8), 32'(m8.ovf));
        checkOutput("latency8", cyc - m8.acc, m8.idx + 1);
      end
    end
  end

  task automatic applyStimulus32(input logic [31:0] v, input logic [31:0] ei, input logic eis, input logic eo);
    @(negedge clk);
    x32 = v; start32 = 1'b1;
    @(negedge clk);
    start32 = 1'b0;
    sb32.push_back('{ei, eis, eo, cyc});
  endtask

  task automatic applyStimulus8(input logic [7:0] v, input logic [31:0] ei, input logic eis, input logic eo);
    @(negedge clk);
    x8 = v; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    sb8.push_back('{ei, eis, eo, cyc});
  endtask

  task automatic waitIdle(input int lim);
    int n = 0;
    while ((sb32.size() != 0 || sb8.size() != 0) && n < lim) begin
      @(negedge clk);
      n++;
    end
    if (sb32.size() != 0 || sb8.size() != 0) begin
      checkOutput("timeout", sb32.size() + sb8.size(), 0);
      sb32.delete();
      sb8.delete();
    end
  endtask

  task automatic checkZero32(input string tag);
    checkOutput({tag, "_busy"}, 32'(busy32), 0);
    checkOutput({tag, "_done"}, 32'(done32), 0);
    checkOutput({tag, "_idx"}, idx32, 0);
    checkOutput({tag, "_is_fib"}, 32'(isf32), 0);
    checkOutput({tag, "_ovf"}, 32'(ovf32), 0);
  endtask

  logic [31:0] ei;
  logic        eis, eo;
  logic [31:0] vals32[6] = '{2, 4, 7, 100, 1000, 4181};
  logic [7:0]  vals8[4]  = '{200, 144, 255, 1};

  initial begin
    repeat (2) @(negedge clk);
    rst = 1'b0;
    checkZero32("reset32");
    checkOutput("reset8_busy", 32'(busy8), 0);
    checkOutput("reset8_idx", 32'(idx8), 0);

    applyStimulus32(55, 10, 1'b1, 1'b0);
    waitIdle(40);
    applyStimulus32(10, 7, 1'b0, 1'b0);
    waitIdle(40);
    applyStimulus32(0, 0, 1'b1, 1'b0);
    waitIdle(40);
    applyStimulus32(1, 1, 1'b1, 1'b0);
    waitIdle(40);

    applyStimulus8(250, 13, 1'b0, 1'b1);
    waitIdle(40);
    applyStimulus8(233, 13, 1'b1, 1'b0);
    waitIdle(40);

    // Start while busy is ignored; start in the done cycle is accepted.
    applyStimulus32(55, 10, 1'b1, 1'b0);
    repeat (3) @(negedge clk);
    x32 = 3; start32 = 1'b1;
    @(negedge clk);
    start32 = 1'b0; x32 = 99;
    begin
      int n = 0;
      while (done32 !== 1'b1 && n < 40) begin
        @(negedge clk);
        n++;
      end
      checkOutput("done_seen", 32'(done32), 1);
    end
    x32 = 3; start32 = 1'b1;
    @(negedge clk);
    start32 = 1'b0;
    sb32.push_back('{32'd4, 1'b1, 1'b0, cyc});
    waitIdle(40);

    // Reset mid-operation abandons the computation without a done pulse.
    applyStimulus32(55, 10, 1'b1, 1'b0);
    repeat (4) @(negedge clk);
    rst = 1'b1;
    sb32.delete();
    @(negedge clk);
    rst = 1'b0;
    checkZero32("midrst");
    repeat (15) @(negedge clk);
    applyStimulus32(8, 6, 1'b1, 1'b0);
    waitIdle(40);

    foreach (vals32[k]) begin
      model(vals32[k], 32, ei, eis, eo);
      applyStimulus32(vals32[k], ei, eis, eo);
      waitIdle(60);
    end
    foreach (vals8[k]) begin
      model(32'(vals8[k]), 8, ei, eis, eo);
      applyStimulus8(vals8[k], ei, eis, eo);
      waitIdle(60);
    end

    repeat (3) @(negedge clk);
    checkOutput("sb_empty", sb32.size() + sb8.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
